// File: rtl/gen_lfsr.sv
// Fibonacci-style LFSR with serial/parallel load, single-step control and
// an autonomous run-burst mode driven by a down-counter.
module gen_lfsr #(
  parameter int unsigned           WIDTH    = 23,
  parameter logic [WIDTH-1:0]      TAP_MASK = 23'h700080,
  parameter int unsigned           CLK_BIT  = 10,
  parameter int unsigned           LEN_W    = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       mode,
  input  logic             trigger,
  input  logic             shift_bit,
  input  logic [WIDTH-1:0] load_data,
  input  logic             burst_start,
  input  logic [LEN_W-1:0] burst_len,
  output logic [WIDTH-1:0] Z,
  output logic             out_bit,
  output logic             clk_bit,
  output logic             zero_flag,
  output logic             busy,
  output logic             burst_done
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] count;
  logic             fb;
  logic [WIDTH-1:0] run_next;
  logic [WIDTH-1:0] serial_next;

  // Feedback parity over the tapped bits and the two candidate next states.
  always_comb begin
    fb          = ^(Z & TAP_MASK);
    run_next    = {Z[WIDTH-2:0], fb};
    serial_next = {Z[WIDTH-2:0], fb ^ shift_bit};
  end

  assign out_bit   = Z[WIDTH-1];
  assign clk_bit   = Z[CLK_BIT];
  assign zero_flag = (Z == '0);

  // Register update and IDLE/BURST control; burst_start takes priority over
  // trigger in IDLE, and BURST ignores all control inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      Z          <= '0;
      count      <= '0;
      state      <= IDLE;
      busy       <= 1'b0;
      burst_done <= 1'b0;
    end else begin
      burst_done <= 1'b0;
      case (state)
        IDLE: begin
          if (burst_start) begin
            if (burst_len != '0) begin
              count <= burst_len;
              state <= BURST;
              busy  <= 1'b1;
            end else begin
              burst_done <= 1'b1;
            end
          end else if (trigger) begin
            case (mode)
              2'b01:   Z <= serial_next;
              2'b10:   Z <= run_next;
              2'b11:   Z <= load_data;
              default: Z <= Z;
            endcase
          end
        end
        BURST: begin
          Z     <= run_next;
          count <= count - LEN_W'(1);
          if (count == LEN_W'(1)) begin
            state      <= IDLE;
            busy       <= 1'b0;
            burst_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
